fabosc_clken_gen: RTL and testbench

- Parametrised multi-channel clock-enable generator running off the fabric on-chip oscillator clock (RCOSC_25_50MHZ_O2F routed through CLKINT).
- Produces NUM_CH single-cycle enable strobes with independent, runtime-programmable divide ratios.
- Successor to the bare oscillator wrapper: adds divided enables, glitch-free ratio change, channel gating and phase sync, so downstream logic stays on one global clock.

---
 rtl/fabosc_clken_gen.sv | 135 +++++++++++++
 tb/tb_fabosc_clken_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fabosc_clken_gen.sv
// Multi-channel clock-enable generator on the fabric oscillator clock, with per-channel
// divide ratios, glitch-free ratio change and phase sync. Define FABOSC_CLKMON_EN to add the REF_IN monitor.
module fabosc_clken_gen #(
    parameter  int NUM_CH      = 4,
    parameter  int DIV_W       = 16,
    parameter  int DEFAULT_DIV = 50,
    parameter  int MON_WINDOW  = 1024,
    parameter  int MON_MIN     = 1,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [NUM_CH-1:0] CH_EN,
    input  logic              SYNC,
    input  logic              CFG_WE,
    input  logic [CH_W-1:0]   CFG_CH,
    input  logic [DIV_W-1:0]  CFG_DIV,
    output logic              CFG_ERR,
    output logic [NUM_CH-1:0] CFG_PEND,
    output logic [NUM_CH-1:0] CLKEN,
    input  logic              REF_IN,
    output logic              REF_LOST
);

    typedef logic [DIV_W-1:0] div_t;

    localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

    div_t              cnt_q      [NUM_CH];
    div_t              cnt_d      [NUM_CH];
    div_t              act_q      [NUM_CH];
    div_t              pend_val_q [NUM_CH];
    div_t              pend_val_d [NUM_CH];
    div_t              ratio      [NUM_CH];
    logic [NUM_CH-1:0] apply;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] pend_d;
    logic [NUM_CH-1:0] clken_d;
    logic              wr_valid;

    assign wr_valid = CFG_WE && ({1'b0, CFG_CH} < NUM_CH_V);

    // A pending ratio is only taken over at cnt==0, so a running period is never cut short.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // NOTE: every output of this block is assigned on every path, so no latch is inferred.
            apply[i]      = CFG_PEND[i] && (cnt_q[i] == '0);
            hit[i]        = wr_valid && (CFG_CH == CH_W'(i));
            ratio[i]      = apply[i] ? pend_val_q[i] : act_q[i];
            pend_val_d[i] = hit[i] ? CFG_DIV : pend_val_q[i];
            pend_d[i]     = hit[i] || (CFG_PEND[i] && !apply[i]);
            cnt_d[i]      = '0;
            clken_d[i]    = 1'b0;
            if (!SYNC && CH_EN[i]) begin
                if (cnt_q[i] == '0) begin
                    clken_d[i] = 1'b1;
                    cnt_d[i]   = (ratio[i] == '0) ? '0 : ratio[i] - div_t'(1);
                end else begin
                    cnt_d[i] = cnt_q[i] - div_t'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            // NOTE: the per-channel arrays are plain flops, so all of them take a reset value.
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]      <= '0;
                act_q[i]      <= div_t'(DEFAULT_DIV);
                pend_val_q[i] <= '0;
            end
            CFG_PEND <= '0;
            CLKEN    <= '0;
            CFG_ERR  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]      <= cnt_d[i];
                act_q[i]      <= ratio[i];
                pend_val_q[i] <= pend_val_d[i];
            end
            CFG_PEND <= pend_d;
            CLKEN    <= clken_d;
            CFG_ERR  <= CFG_WE && !wr_valid;
        end
    end

`ifdef FABOSC_CLKMON_EN
    localparam int WIN_W = (MON_WINDOW > 1) ? $clog2(MON_WINDOW) : 1;
    localparam int EC_W  = (MON_MIN > 0) ? $clog2(MON_MIN + 1) : 1;

    logic             ref_meta;
    logic             ref_sync;
    logic             ref_prev;
    logic             ref_rise;
    logic             win_end;
    logic [WIN_W-1:0] win_cnt;
    logic [EC_W-1:0]  edge_cnt;
    logic [EC_W-1:0]  edge_sum;

    assign ref_rise = ref_sync && !ref_prev;
    assign win_end  = (win_cnt == WIN_W'(MON_WINDOW - 1));
    // Saturate at MON_MIN: only "enough edges or not" matters at the window end.
    assign edge_sum = (edge_cnt >= EC_W'(MON_MIN)) ? edge_cnt : edge_cnt + EC_W'(ref_rise);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ref_meta <= 1'b0;
            ref_sync <= 1'b0;
            ref_prev <= 1'b0;
            win_cnt  <= '0;
            edge_cnt <= '0;
            REF_LOST <= 1'b0;
        end else begin
            ref_meta <= REF_IN;
            ref_sync <= ref_meta;
            ref_prev <= ref_sync;
            if (win_end) begin
                REF_LOST <= (edge_sum < EC_W'(MON_MIN));
                edge_cnt <= '0;
                win_cnt  <= '0;
            end else begin
                edge_cnt <= edge_sum;
                win_cnt  <= win_cnt + WIN_W'(1);
            end
        end
    end
`else
    logic unused_ref;
    assign unused_ref = REF_IN;
    assign REF_LOST   = 1'b0;
`endif

endmodule

// File: tb/tb_fabosc_clken_gen.sv
// Randomised self-checking bench for fabosc_clken_gen: a cycle-level reference model
// derived from the channel rules, compared every cycle, plus hand-computed literal pins.
module tb_fabosc_clken_gen;

    localparam int NCH  = 5;
    localparam int DW   = 16;
    localparam int DEF  = 50;
    localparam int MW   = 64;
    localparam int MM   = 2;
    localparam int CHW  = 3;

    logic           CLK = 1'b0;
    logic           RESETN = 1'b0;
    logic [NCH-1:0] CH_EN = '0;
    logic           SYNC = 1'b0;
    logic           CFG_WE = 1'b0;
    logic [CHW-1:0] CFG_CH = '0;
    logic [DW-1:0]  CFG_DIV = '0;
    logic           CFG_ERR;
    logic [NCH-1:0] CFG_PEND;
    logic [NCH-1:0] CLKEN;
    logic           REF_IN = 1'b0;
    logic           REF_LOST;

    fabosc_clken_gen #(
        .NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(DEF), .MON_WINDOW(MW), .MON_MIN(MM)
    ) dut (
        .CLK(CLK), .RESETN(RESETN), .CH_EN(CH_EN), .SYNC(SYNC), .CFG_WE(CFG_WE),
        .CFG_CH(CFG_CH), .CFG_DIV(CFG_DIV), .CFG_ERR(CFG_ERR), .CFG_PEND(CFG_PEND),
        .CLKEN(CLKEN), .REF_IN(REF_IN), .REF_LOST(REF_LOST)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: "cycles left until the next strobe" per channel, active/pending ratios.
    int             left     [NCH];
    int             act_div  [NCH];
    int             pend_div [NCH];
    bit             pend_on  [NCH];
    logic [NCH-1:0] e_clken;
    logic [NCH-1:0] e_pend;
    logic           e_err;
    logic           e_lost;
    bit             ref_last, rise_d0, rise_d1, rise_now;
    int             win_pos, win_edges;
    int             use_div;

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < NCH; i++) begin
                left[i] = 0; act_div[i] = DEF; pend_div[i] = 0; pend_on[i] = 0;
            end
            e_clken = '0; e_pend = '0; e_err = 1'b0; e_lost = 1'b0;
            ref_last = 0; rise_d0 = 0; rise_d1 = 0; win_pos = 0; win_edges = 0;
        end else begin
            e_err = CFG_WE && (int'(CFG_CH) >= NCH);
            for (int i = 0; i < NCH; i++) begin
                use_div = act_div[i];
                if (pend_on[i] && left[i] == 0) begin
                    act_div[i] = pend_div[i];
                    use_div    = pend_div[i];
                    pend_on[i] = 0;
                end
                if (use_div < 1) use_div = 1;
                e_clken[i] = 1'b0;
                if (SYNC || !CH_EN[i]) left[i] = 0;
                else if (left[i] == 0) begin
                    e_clken[i] = 1'b1;
                    left[i]    = use_div - 1;
                end else left[i] = left[i] - 1;
                if (CFG_WE && int'(CFG_CH) == i) begin
                    pend_div[i] = int'(CFG_DIV);
                    pend_on[i]  = 1;
                end
                e_pend[i] = pend_on[i];
            end
`ifdef FABOSC_CLKMON_EN
            // A REF_IN rise sampled at edge k is seen by the window two edges later.
            rise_now = rise_d1;
            rise_d1  = rise_d0;
            rise_d0  = REF_IN && !ref_last;
            ref_last = REF_IN;
            win_edges += int'(rise_now);
            win_pos++;
            if (win_pos == MW) begin
                e_lost    = (win_edges < MM);
                win_pos   = 0;
                win_edges = 0;
            end
`endif
        end
    end

    bit run_cmp = 0;
    always @(negedge CLK) begin
        if (run_cmp) begin
            check("clken", CLKEN, e_clken);
            check("cfg_pend", CFG_PEND, e_pend);
            check("cfg_err", CFG_ERR, e_err);
            check("ref_lost", REF_LOST, e_lost);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        CH_EN = '0; SYNC = 1'b0; CFG_WE = 1'b0; CFG_CH = '0; CFG_DIV = '0;
    endtask

    task automatic do_reset();
        idle();
        RESETN = 1'b0;
        step();
        step();
        RESETN = 1'b1;
    endtask

    task automatic write_cfg(input int ch, input int div);
        CFG_WE = 1'b1; CFG_CH = CHW'(ch); CFG_DIV = DW'(div);
        step();
        CFG_WE = 1'b0;
    endtask

    initial begin
        do_reset();
        run_cmp = 1;

        // Reset values
        check("rst_clken", CLKEN, 0);
        check("rst_pend", CFG_PEND, 0);
        check("rst_err", CFG_ERR, 0);
        check("rst_lost", REF_LOST, 0);

        // Default ratio 50 on channel 0
        CH_EN = 5'b00001;
        for (int c = 1; c <= 101; c++) begin
            step();
            if (c == 1 || c == 51 || c == 101) check("t1_strobe", CLKEN, 5'b00001);
            else if (c == 50 || c == 2) check("t1_gap", CLKEN, 0);
        end

        // Ratio change 50 -> 3 written mid-period
        do_reset();
        CH_EN = 5'b00001;
        for (int c = 1; c <= 57; c++) begin
            step();
            if (c == 10) begin CFG_WE = 1'b1; CFG_CH = 3'd0; CFG_DIV = 16'd3; end
            if (c == 11) begin CFG_WE = 1'b0; check("t2_pend_set", CFG_PEND[0], 1); end
            if (c == 50) check("t2_pend_held", CFG_PEND[0], 1);
            if (c == 51) begin check("t2_pend_clr", CFG_PEND[0], 0); check("t2_s51", CLKEN[0], 1); end
            if (c == 52 || c == 53) check("t2_no_short", CLKEN[0], 0);
            if (c == 54 || c == 57) check("t2_s", CLKEN[0], 1);
        end

        // Ratios 0 and 1 give a continuous enable
        do_reset();
        CFG_WE = 1'b1; CFG_CH = 3'd1; CFG_DIV = 16'd0;
        for (int c = 1; c <= 21; c++) begin
            step();
            if (c == 1) begin CFG_WE = 1'b0; check("t3_pend", CFG_PEND, 5'b00010); end
            if (c == 2) begin check("t3_applied", CFG_PEND, 0); CH_EN = 5'b00010; end
            if (c >= 3 && c <= 20) check("t3_cont", CLKEN[1], 1);
            if (c == 12) begin CFG_WE = 1'b1; CFG_CH = 3'd1; CFG_DIV = 16'd1; end
            if (c == 13) CFG_WE = 1'b0;
            if (c == 20) CH_EN = '0;
            if (c == 21) check("t3_drop", CLKEN[1], 0);
        end

        // SYNC aligns channels at 5, 7, 9, 11
        do_reset();
        write_cfg(0, 5);
        write_cfg(1, 7);
        write_cfg(2, 9);
        write_cfg(3, 11);
        step();
        step();
        check("t4_applied", CFG_PEND, 0);
        CH_EN = 5'b01111;
        for (int c = 1; c <= 113; c++) begin
            step();
            if (c == 100) SYNC = 1'b1;
            if (c == 101) begin SYNC = 1'b0; check("t4_sync_clr", CLKEN, 0); end
            if (c == 102) check("t4_aligned", CLKEN, 5'b01111);
            if (c == 106) check("t4_gap", CLKEN, 0);
            if (c == 107) check("t4_ch0", CLKEN[0], 1);
            if (c == 109) check("t4_ch1", CLKEN[1], 1);
            if (c == 111) check("t4_ch2", CLKEN[2], 1);
            if (c == 113) check("t4_ch3", CLKEN[3], 1);
        end

        // Invalid channel write
        write_cfg(5, 3);
        check("t5_err", CFG_ERR, 1);
        check("t5_pend", CFG_PEND, 0);
        step();
        check("t5_err_clr", CFG_ERR, 0);
        write_cfg(7, 2);
        check("t5_err7", CFG_ERR, 1);
        for (int c = 0; c < 30; c++) step();

`ifdef FABOSC_CLKMON_EN
        // Reference monitor: present, absent, resumed
        do_reset();
        for (int c = 0; c < 200; c++) begin
            if (c % 10 == 0) REF_IN = ~REF_IN;
            step();
        end
        check("mon_present", REF_LOST, 0);
        REF_IN = 1'b0;
        for (int c = 0; c < 200; c++) step();
        check("mon_lost", REF_LOST, 1);
        for (int c = 0; c < 200; c++) begin
            if (c % 10 == 0) REF_IN = ~REF_IN;
            step();
        end
        check("mon_resumed", REF_LOST, 0);
`endif

        // Randomised traffic, with one reset mid-run
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if (n == 2000) do_reset();
            SYNC   = ($urandom_range(0, 59) == 0);
            CFG_WE = ($urandom_range(0, 7) == 0);
            CFG_CH = CHW'($urandom_range(0, 7));
            CFG_DIV = ($urandom_range(0, 9) == 0) ? DW'($urandom_range(13, 60)) : DW'($urandom_range(0, 12));
            if ($urandom_range(0, 19) == 0) CH_EN = NCH'($urandom);
            if ($urandom_range(0, 5) == 0) REF_IN = ~REF_IN;
            step();
        end

        idle();
        step();
        run_cmp = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
